// File: rtl/step_segment_runner.sv
// Pops 128-bit motion records from the record fifo and plays each one out as a
// burst of fixed-width step pulses with a direction setup lead-in.
module step_segment_runner #(
  parameter int WordSize    = 8,
  parameter int RecordWords = 16,
  parameter int CountBits   = 32,
  parameter int PulseWidth  = 4,
  parameter int DirSetup    = 2
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            enable,
  input  logic                            abort,
  input  logic                            fifo_empty,
  input  logic [WordSize*RecordWords-1:0] fifo_data,
  output logic                            fifo_read_en,
  output logic                            step,
  output logic                            dir,
  output logic                            busy,
  output logic [CountBits-1:0]            steps_left
);

  localparam int R = WordSize * RecordWords;
  localparam int SetupBits = (DirSetup > 1) ? $clog2(DirSetup) : 1;
  localparam logic [CountBits-1:0] MinPeriod = CountBits'(2 * PulseWidth);
  localparam logic [CountBits-1:0] PulseLen  = CountBits'(PulseWidth);
  localparam logic [SetupBits-1:0] SetupLast = SetupBits'(DirSetup - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    RUN   = 2'd2
  } state_t;

  state_t               state, state_nxt;
  logic [SetupBits-1:0] setup_cnt, setup_nxt;
  logic [CountBits-1:0] phase, phase_nxt, phase_inc;
  logic [CountBits-1:0] period_q, period_nxt;
  logic [CountBits-1:0] left_nxt;
  logic                 step_nxt, dir_nxt;

  logic [CountBits-1:0] rec_count, rec_period, rec_period_eff;
  logic                 rec_dir;
  logic                 unused_reserved;

  assign rec_count      = fifo_data[CountBits-1:0];
  assign rec_period     = fifo_data[2*CountBits-1:CountBits];
  assign rec_dir        = fifo_data[2*CountBits];
  assign unused_reserved = ^fifo_data[R-1:2*CountBits+1];

  // Periods shorter than two pulse widths are stretched so every pulse has a low half.
  assign rec_period_eff = (rec_period < MinPeriod) ? MinPeriod : rec_period;

  assign fifo_read_en = (state == IDLE) && enable && !fifo_empty && !abort;
  assign busy         = (state != IDLE);
  assign phase_inc    = phase + CountBits'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      setup_cnt  <= '0;
      phase      <= '0;
      period_q   <= '0;
      steps_left <= '0;
      dir        <= 1'b0;
      step       <= 1'b0;
    end else begin
      state      <= state_nxt;
      setup_cnt  <= setup_nxt;
      phase      <= phase_nxt;
      period_q   <= period_nxt;
      steps_left <= left_nxt;
      dir        <= dir_nxt;
      step       <= step_nxt;
    end
  end

  // step is computed one cycle ahead from the next phase so the output is a clean flop.
  always_comb begin
    state_nxt  = state;
    setup_nxt  = setup_cnt;
    phase_nxt  = phase;
    period_nxt = period_q;
    left_nxt   = steps_left;
    dir_nxt    = dir;
    step_nxt   = 1'b0;

    if (abort) begin
      state_nxt = IDLE;
      setup_nxt = '0;
      phase_nxt = '0;
      left_nxt  = '0;
    end else begin
      case (state)
        IDLE: begin
          left_nxt = '0;
          if (fifo_read_en && (rec_count != '0)) begin
            state_nxt  = SETUP;
            setup_nxt  = '0;
            left_nxt   = rec_count;
            period_nxt = rec_period_eff;
            dir_nxt    = rec_dir;
          end
        end
        SETUP: begin
          if (setup_cnt == SetupLast) begin
            state_nxt = RUN;
            phase_nxt = '0;
            step_nxt  = 1'b1;
          end else begin
            setup_nxt = setup_cnt + SetupBits'(1);
          end
        end
        RUN: begin
          if (phase == period_q - CountBits'(1)) begin
            left_nxt  = steps_left - CountBits'(1);
            phase_nxt = '0;
            if (steps_left == CountBits'(1)) begin
              state_nxt = IDLE;
            end else begin
              step_nxt = 1'b1;
            end
          end else begin
            phase_nxt = phase_inc;
            step_nxt  = (phase_inc < PulseLen);
          end
        end
        default: begin
          state_nxt = IDLE;
          left_nxt  = '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_step_segment_runner.sv
// Randomised and directed bench for step_segment_runner, checked every cycle
// against a timeline model built from the segment arithmetic.
module tb_step_segment_runner;

  localparam int R  = 128;
  localparam int CB = 32;
  localparam int PW = 4;
  localparam int DS = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          enable = 1'b0;
  logic          abort = 1'b0;
  logic          fifo_empty = 1'b1;
  logic [R-1:0]  fifo_data = '0;
  logic          fifo_read_en;
  logic          step;
  logic          dir;
  logic          busy;
  logic [CB-1:0] steps_left;

  always #5 clk = ~clk;

  step_segment_runner #(
    .WordSize(8), .RecordWords(16), .CountBits(CB), .PulseWidth(PW), .DirSetup(DS)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .abort(abort),
    .fifo_empty(fifo_empty), .fifo_data(fifo_data), .fifo_read_en(fifo_read_en),
    .step(step), .dir(dir), .busy(busy), .steps_left(steps_left)
  );

  logic [R-1:0] fifo_q[$];
  bit           hold_empty;
  int           checks, errors;

  // Model: while busy, m_k counts cycles since the pop edge (1 = first SETUP cycle).
  bit      m_busy, m_dir, m_rd, rd_dut;
  longint  m_k, m_n, m_p;

  int  pops, rises, high_cycles, busy_cycles, cyc;
  int  first_pop_cyc, last_pop_cyc, pop_gap, first_rise_cyc, last_rise_cyc, rise_gap;
  bit  prev_step;

  task automatic checkOutput(input string name, input longint actual, input longint expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0d expected=%0d", name, actual, expected);
    end
  endtask

  function automatic logic [R-1:0] makeRecord(input int unsigned cnt, input int unsigned per, input bit d);
    logic [R-1:0] rec;
    rec = {$urandom(), $urandom(), $urandom(), $urandom()};
    rec[31:0]  = cnt;
    rec[63:32] = per;
    rec[64]    = d;
    return rec;
  endfunction

  task automatic refreshFifo();
    fifo_empty = hold_empty || (fifo_q.size() == 0);
    if (fifo_q.size() != 0) fifo_data = fifo_q[0];
    else fifo_data = {$urandom(), $urandom(), $urandom(), $urandom()};
  endtask

  task automatic resetModel();
    m_busy = 1'b0;
    m_dir  = 1'b0;
    m_k    = 0;
    m_n    = 0;
    m_p    = 0;
  endtask

  task automatic clearStats();
    pops = 0; rises = 0; high_cycles = 0; busy_cycles = 0; cyc = 0;
    first_pop_cyc = 0; last_pop_cyc = 0; pop_gap = 0;
    first_rise_cyc = 0; last_rise_cyc = 0; rise_gap = 0;
    prev_step = step;
  endtask

  task automatic compareCycle();
    longint e_step, e_left, e_busy, r;
    e_step = 0; e_left = 0; e_busy = 0;
    if (m_busy) begin
      e_busy = 1;
      if (m_k <= DS) begin
        e_left = m_n;
      end else begin
        r      = m_k - DS - 1;
        e_step = ((r % m_p) < PW) ? 1 : 0;
        e_left = m_n - r / m_p;
      end
    end
    m_rd = !m_busy && enable && !fifo_empty && !abort;
    checkOutput("step", longint'(step), e_step);
    checkOutput("dir", longint'(dir), longint'(m_dir));
    checkOutput("busy", longint'(busy), e_busy);
    checkOutput("steps_left", longint'(steps_left), e_left);
    checkOutput("fifo_read_en", longint'(fifo_read_en), longint'(m_rd));

    cyc++;
    if (fifo_read_en) begin
      pops++;
      if (pops > 1) pop_gap = cyc - last_pop_cyc;
      else first_pop_cyc = cyc;
      last_pop_cyc = cyc;
    end
    if (step && !prev_step) begin
      rises++;
      if (rises > 1) rise_gap = cyc - last_rise_cyc;
      else first_rise_cyc = cyc;
      last_rise_cyc = cyc;
    end
    prev_step = step;
    high_cycles += int'(step);
    busy_cycles += int'(busy);
  endtask

  task automatic advanceModel();
    logic [R-1:0] head;
    if (abort) begin
      m_busy = 1'b0;
    end else if (m_busy) begin
      m_k++;
      if (m_k > DS + m_n * m_p) m_busy = 1'b0;
    end else if (m_rd) begin
      head = fifo_q[0];
      if (head[31:0] != 0) begin
        m_busy = 1'b1;
        m_k    = 1;
        m_n    = longint'(head[31:0]);
        m_p    = longint'(head[63:32]);
        if (m_p < 2 * PW) m_p = 2 * PW;
        m_dir  = head[64];
      end
    end
  endtask

  task automatic stepCycle();
    @(negedge clk);
    compareCycle();
    rd_dut = fifo_read_en;
    @(posedge clk);
    if (rst_n) advanceModel();
    #1;
    if (rd_dut && fifo_q.size() > 0) void'(fifo_q.pop_front());
    refreshFifo();
  endtask

  task automatic applyStimulus(input int n);
    for (int i = 0; i < n; i++) stepCycle();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    hold_empty = 1'b0;
    resetModel();
    refreshFifo();
    clearStats();
    #1;
    applyStimulus(2);
    checkOutput("reset_step", longint'(step), 0);
    checkOutput("reset_busy", longint'(busy), 0);
    checkOutput("reset_steps_left", longint'(steps_left), 0);
    rst_n = 1'b1;

    $display("[TB] single segment count=3 period=10 dir=1");
    fifo_q.push_back(makeRecord(3, 10, 1'b1));
    enable = 1'b1;
    refreshFifo();
    clearStats();
    applyStimulus(40);
    checkOutput("t1_pops", pops, 1);
    checkOutput("t1_rises", rises, 3);
    checkOutput("t1_high_cycles", high_cycles, 12);
    checkOutput("t1_busy_cycles", busy_cycles, 32);
    checkOutput("t1_first_rise_offset", first_rise_cyc - first_pop_cyc, 3);
    checkOutput("t1_rise_gap", rise_gap, 10);

    $display("[TB] short period stretched to 8");
    fifo_q.push_back(makeRecord(2, 3, 1'b0));
    refreshFifo();
    clearStats();
    applyStimulus(30);
    checkOutput("t2_rises", rises, 2);
    checkOutput("t2_high_cycles", high_cycles, 8);
    checkOutput("t2_busy_cycles", busy_cycles, 18);
    checkOutput("t2_rise_gap", rise_gap, 8);

    $display("[TB] back-to-back records");
    fifo_q.push_back(makeRecord(2, 8, 1'b0));
    fifo_q.push_back(makeRecord(1, 8, 1'b1));
    refreshFifo();
    clearStats();
    applyStimulus(40);
    checkOutput("t3_pops", pops, 2);
    checkOutput("t3_rises", rises, 3);
    checkOutput("t3_busy_cycles", busy_cycles, 28);
    checkOutput("t3_pop_gap", pop_gap, 19);

    $display("[TB] zero-count record discarded");
    fifo_q.push_back(makeRecord(0, 5, 1'b1));
    fifo_q.push_back(makeRecord(1, 5, 1'b0));
    refreshFifo();
    clearStats();
    applyStimulus(20);
    checkOutput("t4_pops", pops, 2);
    checkOutput("t4_pop_gap", pop_gap, 1);
    checkOutput("t4_rises", rises, 1);
    checkOutput("t4_busy_cycles", busy_cycles, 10);

    $display("[TB] abort after fifth step");
    fifo_q.push_back(makeRecord(100, 10, 1'b1));
    fifo_q.push_back(makeRecord(2, 10, 1'b0));
    refreshFifo();
    clearStats();
    for (int i = 0; i < 300 && rises < 5; i++) stepCycle();
    checkOutput("t5_reached_rise5", rises, 5);
    abort  = 1'b1;
    enable = 1'b0;
    stepCycle();
    abort = 1'b0;
    checkOutput("t5_busy_after_abort", longint'(busy), 0);
    checkOutput("t5_step_after_abort", longint'(step), 0);
    checkOutput("t5_left_after_abort", longint'(steps_left), 0);
    checkOutput("t5_dir_held", longint'(dir), 1);
    applyStimulus(10);
    checkOutput("t5_pops", pops, 1);
    checkOutput("t5_fifo_left", fifo_q.size(), 1);
    fifo_q.delete();
    enable = 1'b1;
    refreshFifo();
    clearStats();
    applyStimulus(20);
    checkOutput("t5_empty_pops", pops, 0);

    $display("[TB] async reset mid-run");
    fifo_q.push_back(makeRecord(100, 10, 1'b1));
    refreshFifo();
    clearStats();
    for (int i = 0; i < 300 && !(rises >= 2 && step); i++) stepCycle();
    checkOutput("t6_step_high_before_reset", longint'(step), 1);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("t6_step_reset", longint'(step), 0);
    checkOutput("t6_busy_reset", longint'(busy), 0);
    checkOutput("t6_dir_reset", longint'(dir), 0);
    checkOutput("t6_left_reset", longint'(steps_left), 0);
    resetModel();
    enable = 1'b0;
    fifo_q.push_back(makeRecord(3, 10, 1'b0));
    refreshFifo();
    applyStimulus(3);
    rst_n = 1'b1;
    clearStats();
    applyStimulus(20);
    checkOutput("t6_pops_disabled", pops, 0);
    checkOutput("t6_fifo_left", fifo_q.size(), 1);

    $display("[TB] randomised traffic");
    fifo_q.delete();
    for (int i = 0; i < 1500; i++) begin
      if (fifo_q.size() < 3 && ($urandom() % 4) == 0)
        fifo_q.push_back(makeRecord($urandom() % 5, $urandom() % 13, 1'($urandom() % 2)));
      enable     = (($urandom() % 10) != 0);
      abort      = (($urandom() % 40) == 0);
      hold_empty = (($urandom() % 8) == 0);
      refreshFifo();
      stepCycle();
    end
    abort = 1'b0;
    hold_empty = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
